// File: rtl/fifo_burst_reader_if.sv
// Bundles the FIFO read port and the outgoing stream of fifo_burst_reader.
// Handshake: a stream word transfers on any rclk edge where out_valid & out_ready;
// out_valid/out_data never change while out_valid=1 and out_ready=0.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rinc;
  logic                  rempty;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport master (
    output rinc,
    input  rempty,
    input  rdata,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  rinc,
    output rempty,
    output rdata,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-domain burst consumer: pops burst_len FIFO words into a 2-entry skid
// buffer, streams them out in order, and keeps a word count and XOR checksum.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  fifo_burst_reader_if.master   bus,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_out,
  output logic [DATA_WIDTH-1:0] checksum,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  pops_left_q, pops_left_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d;
  logic [DATA_WIDTH-1:0] data1_q, data1_d;
  logic                  valid_q, valid_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic                  rinc_c;
  logic                  fire;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q     <= S_IDLE;
      pops_left_q <= '0;
      occ_q       <= 2'd0;
      data0_q     <= '0;
      data1_q     <= '0;
      valid_q     <= 1'b0;
      words_q     <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      pops_left_q <= pops_left_d;
      occ_q       <= occ_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      valid_q     <= valid_d;
      words_q     <= words_d;
      csum_q      <= csum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pops_left_d = pops_left_q;
    occ_d       = occ_q;
    data0_d     = data0_q;
    data1_d     = data1_q;
    words_d     = words_q;
    csum_d      = csum_q;
    rinc_c      = 1'b0;
    fire        = valid_q & bus.out_ready;

    if (fire) begin
      words_d = words_q + LEN_WIDTH'(1);
      csum_d  = csum_q ^ data0_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          words_d = '0;
          csum_d  = '0;
          if (burst_len != '0) begin
            state_d     = S_READ;
            pops_left_d = burst_len;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_READ: begin
        // A full buffer may still take a word when its head leaves this cycle.
        rinc_c = !bus.rempty & ((occ_q != 2'd2) | fire);
        if (rinc_c) begin
          pops_left_d = pops_left_q - LEN_WIDTH'(1);
          if (pops_left_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((occ_q == 2'd0) || ((occ_q == 2'd1) && fire)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case ({rinc_c, fire})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) data0_d = bus.rdata;
        else               data1_d = bus.rdata;
      end
      2'b01: begin
        occ_d   = occ_q - 2'd1;
        data0_d = data1_q;
      end
      2'b11: begin
        // Head leaves and a new word arrives: occupancy holds, order shifts.
        if (occ_q == 2'd1) begin
          data0_d = bus.rdata;
        end else begin
          data0_d = data1_q;
          data1_d = bus.rdata;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase

    valid_d = (occ_d != 2'd0);
  end

  assign bus.rinc      = rinc_c;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data0_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign words_out     = words_q;
  assign checksum      = csum_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: directed vector table, hand-written corner
// sequences and randomized bursts checked against a transaction-level model.
module tb_fifo_burst_reader;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          start = 1'b0;
  logic [LW-1:0] burst_len = '0;
  logic          busy, done;
  logic [LW-1:0] words_out;
  logic [DW-1:0] checksum;
  logic [1:0]    dbg_state;

  fifo_burst_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .start     (start),
    .burst_len (burst_len),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .words_out (words_out),
    .checksum  (checksum),
    .dbg_state (dbg_state)
  );

  always #10 rclk = ~rclk;

  // Bench FIFO contents and the scoreboard of words still owed downstream.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rinc_cnt = 0;
  int start_cyc = 0;
  int last_done_cyc = -1;

  // Burst-level model: active between accepted start and the edge after done.
  bit            m_active = 1'b0;
  bit            m_done_next = 1'b0;
  logic [LW-1:0] m_len = '0;
  logic [LW-1:0] m_fires = '0;
  logic [DW-1:0] m_csum = '0;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  typedef struct {
    int          len;
    logic [7:0]  first;
    int          hold;
    logic [7:0]  exp_words;
    logic [7:0]  exp_csum;
    int          exp_rinc;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One read cycle: present FIFO pins, check outputs, advance the model.
  task automatic step();
    logic          rinc_s;
    logic          fire;
    bit            new_done;
    logic [DW-1:0] exp_data;
    bus.rempty = (fifo_q.size() == 0);
    bus.rdata  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    #1;
    check("busy", busy, m_active);
    check("done", done, m_done_next);
    check("words_out", words_out, m_fires);
    check("checksum", checksum, m_csum);
    if (m_done_next) check("done_count", words_out, m_len);
    if (done) last_done_cyc = cyc;
    if (prev_stall) begin
      check("stall_valid", bus.out_valid, 1'b1);
      check("stall_data", bus.out_data, prev_data);
    end
    rinc_s = bus.rinc;
    if (rinc_s) begin
      rinc_cnt++;
      check("rinc_vs_empty", bus.rempty, 1'b0);
    end
    fire = bus.out_valid & bus.out_ready;
    new_done = 1'b0;
    if (fire) begin
      check("fire_in_burst", m_active && (m_fires < m_len), 1'b1);
      check("fire_has_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_data = exp_q.pop_front();
        check("out_data", bus.out_data, exp_data);
        m_csum = m_csum ^ exp_data;
      end
      m_fires = m_fires + 1'b1;
      if (m_active && m_fires == m_len) new_done = 1'b1;
    end
    if (m_done_next) begin
      m_active = 1'b0;
    end else if (!m_active && start) begin
      m_active = 1'b1;
      m_len    = burst_len;
      m_fires  = '0;
      m_csum   = '0;
      if (burst_len == '0) new_done = 1'b1;
    end
    prev_stall = bus.out_valid & !bus.out_ready;
    prev_data  = bus.out_data;
    @(posedge rclk);
    if (rinc_s && fifo_q.size() != 0) void'(fifo_q.pop_front());
    m_done_next = new_done;
    cyc++;
    @(negedge rclk);
  endtask

  task automatic issue_start(input logic [LW-1:0] len);
    start     = 1'b1;
    burst_len = len;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && m_active; i++) step();
    check(name, m_active, 1'b0);
  endtask

  task automatic do_reset();
    rrst_n = 1'b0;
    #1;
    check("rst_rinc", bus.rinc, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_data", bus.out_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_words_out", words_out, 8'h00);
    check("rst_checksum", checksum, 8'h00);
    m_active    = 1'b0;
    m_done_next = 1'b0;
    m_len       = '0;
    m_fires     = '0;
    m_csum      = '0;
    prev_stall  = 1'b0;
    exp_q       = fifo_q;
    @(posedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] head;
    bus.rempty    = 1'b1;
    bus.rdata     = '0;
    bus.out_ready = 1'b0;
    rrst_n        = 1'b1;
    #2;
    do_reset();

    vecs[0] = '{4, 8'h01, 0, 8'h04, 8'h04, -1};
    vecs[1] = '{6, 8'hA0, 5, 8'h06, 8'h01,  2};
    vecs[2] = '{0, 8'h00, 2, 8'h00, 8'h00,  0};
    vecs[3] = '{1, 8'h5A, 0, 8'h01, 8'h5A, -1};
    vecs[4] = '{3, 8'h10, 2, 8'h03, 8'h13,  2};
    vecs[5] = '{8, 8'h00, 3, 8'h08, 8'h00,  2};

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].len; k++) push(vecs[i].first + 8'(k));
      bus.out_ready = (vecs[i].hold == 0);
      rinc_cnt = 0;
      issue_start(LW'(vecs[i].len));
      for (int h = 0; h < vecs[i].hold; h++) step();
      if (vecs[i].exp_rinc >= 0)
        check($sformatf("vec%0d_rinc_while_held", i), rinc_cnt, vecs[i].exp_rinc);
      bus.out_ready = 1'b1;
      wait_idle(200, $sformatf("vec%0d_timeout", i));
      check($sformatf("vec%0d_words_out", i), words_out, vecs[i].exp_words);
      check($sformatf("vec%0d_checksum", i), checksum, vecs[i].exp_csum);
      if (vecs[i].hold == 0 && vecs[i].len > 0)
        check($sformatf("vec%0d_done_cycle", i), last_done_cyc - start_cyc, vecs[i].len + 2);
    end

    // Start pulse during an active burst must be ignored.
    push(8'h21);
    push(8'h22);
    bus.out_ready = 1'b1;
    rinc_cnt = 0;
    issue_start(8'd2);
    start = 1'b1;
    burst_len = 8'd7;
    step();
    start = 1'b0;
    wait_idle(50, "ignored_start_timeout");
    check("ignored_start_words", words_out, 8'd2);
    check("ignored_start_checksum", checksum, 8'h03);
    check("ignored_start_rinc", rinc_cnt, 2);

    // Starved FIFO: words trickle in while the burst waits.
    rinc_cnt = 0;
    issue_start(8'd3);
    push(8'h00);
    void'(fifo_q.pop_back());
    void'(exp_q.pop_back());
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 4; s++) step();
      push(8'h55 + 8'(k) * 8'h11);
    end
    wait_idle(50, "starved_timeout");
    check("starved_words", words_out, 8'd3);
    check("starved_checksum", checksum, 8'h44);
    check("starved_rinc", rinc_cnt, 3);

    // Reset in the middle of a 5-word burst, then a 1-word burst.
    for (int k = 0; k < 5; k++) push(8'h30 + 8'(k));
    bus.out_ready = 1'b1;
    issue_start(8'd5);
    for (int s = 0; s < 20 && m_fires < 2; s++) step();
    check("midrst_two_delivered", m_fires, 8'd2);
    do_reset();
    head = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    issue_start(8'd1);
    wait_idle(50, "midrst_timeout");
    check("midrst_words", words_out, 8'd1);
    check("midrst_checksum", checksum, head);

    // Randomized bursts with random arrivals, backpressure and stray starts.
    for (int b = 0; b < 40; b++) begin
      int len;
      len = $urandom_range(0, 12);
      for (int k = 0; k < $urandom_range(0, len); k++) push(8'($urandom));
      bus.out_ready = 1'($urandom_range(0, 1));
      issue_start(LW'(len));
      for (int c = 0; c < 500 && m_active; c++) begin
        if ($urandom_range(0, 2) == 0) push(8'($urandom));
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          start = 1'b1;
          burst_len = LW'($urandom_range(0, 255));
        end
        step();
        start = 1'b0;
      end
      check($sformatf("rand%0d_timeout", b), m_active, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side controller for the team's asynchronous FIFO (DATA_WIDTH=8, ADDR_WIDTH=6), clocked entirely in the read domain (50 MHz). On a start command it pops exactly `burst_len` words through the FIFO's rinc/rdata/rempty port. It delivers them in order on a registered valid/ready stream through a 2-entry skid buffer. It reports completion, a delivered-word count and a running XOR checksum, giving the bench and downstream logic a clean consumer for data the write side produced.

## Interface
- DATA_WIDTH, 8, FIFO word width.
- LEN_WIDTH, 8, width of burst length and word counter.
- rclk  in  1  read-domain clock; sole clock of the block.
- rrst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- burst_len  in  LEN_WIDTH  number of words to pop; sampled with accepted start.
- rempty  in  1  FIFO empty flag, read domain.
- rdata  in  DATA_WIDTH  FIFO head word; valid whenever rempty=0.
- rinc  out  1  pop strobe to FIFO; combinational.
- out_valid  out  1  registered; out_data holds a valid word.
- out_data  out  DATA_WIDTH  registered head of skid buffer.
- out_ready  in  1  downstream accepts; transfer ("fire") = out_valid & out_ready.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the burst is fully delivered.
- words_out  out  LEN_WIDTH  words delivered in current or last burst.
- checksum  out  DATA_WIDTH  XOR of all words delivered in current or last burst.

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE: rinc=0. If start=1 and burst_len!=0, go to READ, load pops_left=burst_len, and clear words_out and checksum. If start=1 and burst_len==0, clear words_out and checksum and go to DONE.
- READ: rinc = !rempty & (occ<2 | (occ==2 & fire)). Each rinc decrements pops_left. When a rinc brings pops_left to 0, go to DRAIN on the next edge.
- DRAIN: rinc=0. Stay until occ==0, counting the fire in the current cycle. Then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. words_out and checksum hold until the next accepted start.
- start outside IDLE is ignored. The burst_len sample is not re-read mid-burst.
- Skid buffer: 2 entries, occ in 0..2, FIFO order preserved.
  - Pop alone increments occ. Fire alone decrements occ. Pop and fire together leave occ unchanged.
  - out_valid = (occ!=0) and is a register output. out_data is always entry 0.
- Each fire does two things:
  - words_out += 1, modulo 2^LEN_WIDTH.
  - checksum ^= out_data.
- rinc is never asserted when rempty=1, regardless of state.

## Timing
- Reset (rrst_n=0, async) forces:
  - state=IDLE, occ=0, pops_left=0.
  - rinc=0, out_valid=0, out_data=0, busy=0, done=0, words_out=0, checksum=0.
  - Reset mid-burst discards buffered words. No partial done.
- start accepted at edge N → busy=1 after edge N. The first rinc can be in cycle N+1.
- Pop latency: rinc high in cycle M → word is in the buffer and out_valid=1 after edge M (visible in cycle M+1).
- Throughput: with out_ready held 1 and rempty=0, one word per cycle. The burst of L words completes with done asserted in cycle N+L+2.
- Backpressure: out_ready=0 lets at most 2 words accumulate, then rinc=0. out_data/out_valid stay stable while out_valid=1 & out_ready=0.
- FIFO empty mid-burst: rinc=0 and the block waits in READ indefinitely. The block resumes the same cycle rempty deasserts.
- Final pop and fire in the same cycle are both counted.
- done is the only pulse output. busy falls the cycle after done.

## Test plan
- Basic burst: preload FIFO with 0x01..0x04, start with burst_len=4, out_ready=1.
  - out_data 0x01,0x02,0x03,0x04 on consecutive cycles.
  - done one cycle later, words_out=4, checksum=0x04.
- Backpressure: preload 0xA0..0xA5, burst_len=6, out_ready=0 for 5 cycles then 1.
  - Exactly 2 rinc pulses before release, out_data=0xA0 held stable.
  - All 6 delivered in order, checksum=0x01.
- Starved FIFO: burst_len=3 with FIFO empty, then write 0x55, 0x66, 0x77 spaced 4 read cycles apart.
  - rinc only when rempty=0, busy stays 1, done after third word, words_out=3.
- Zero length and ignored start: start with burst_len=0 → done next cycle, words_out=0, no rinc.
  - A start pulse mid-burst (burst_len=2 active) does not alter the count.
- Reset mid-burst: assert rrst_n=0 after 2 of 5 words.
  - All outputs return to reset values immediately. After release, a new burst_len=1 delivers the next FIFO word correctly.
